data_ram_responder: RTL and testbench

Byte-addressed, big-endian data memory that answers the load/store requests issued by the processor control path. It samples RAMEnable, RW, the access size and the address. It performs the word, halfword or byte access after a fixed latency and signals completion on MOC (memory operation complete), which the control unit waits on. It sits opposite the control unit on the RAMEnable/RW/MOC handshake, beside the instruction memory.

---
 rtl/data_ram_responder_pkg.sv | 16 +
 rtl/data_ram_responder_load_extend.sv | 29 ++
 rtl/data_ram_responder.sv | 133 +++++++++++++
 tb/tb_data_ram_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared constants for the data RAM responder and the control unit that drives it.
// Holds the access-size encodings and the responder FSM state type.
package data_ram_responder_pkg;

    localparam logic [1:0] SIZE_WORD    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_BYTE    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

endpackage

// File: rtl/data_ram_responder_load_extend.sv
// Combinational big-endian load formatter: picks word/halfword/byte from four read
// bytes (i_b0 at the lowest address) and zero- or sign-extends sub-word results.
module ram_load_extend
    import data_ram_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [7:0]  i_b0,
    input  logic [7:0]  i_b1,
    input  logic [7:0]  i_b2,
    input  logic [7:0]  i_b3,
    output logic [31:0] o_data
);

    logic w_sign;

    assign w_sign = ~i_unsigned & i_b0[7];

    always_comb begin
        o_data = '0;
        case (i_size)
            SIZE_WORD: o_data = {i_b0, i_b1, i_b2, i_b3};
            SIZE_HALF: o_data = {{16{w_sign}}, i_b0, i_b1};
            SIZE_BYTE: o_data = {{24{w_sign}}, i_b0};
            default:   o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_ram_responder.sv
// Big-endian byte-addressed data memory answering RAMEnable/RW requests with MOC after
// a fixed latency; misaligned, out-of-range or illegal-size accesses raise AddrError.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned LATENCY   = 2
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RAMEnable,
    input  logic        RW,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        AddrError
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem [0:DEPTH-1];

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_rw;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [31:0]            r_data;
    logic                   r_err;

    logic [ADDR_BITS-1:0]   w_a1;
    logic [ADDR_BITS-1:0]   w_a2;
    logic [ADDR_BITS-1:0]   w_a3;
    logic                   w_err;
    logic                   w_done;
    logic                   w_commit;
    logic [31:0]            w_load;

    assign w_a1 = r_addr + ADDR_BITS'(1);
    assign w_a2 = r_addr + ADDR_BITS'(2);
    assign w_a3 = r_addr + ADDR_BITS'(3);

    // Classified on the live inputs so the verdict is latched with the request.
    assign w_err = (Size == SIZE_ILLEGAL)
                || ((Size == SIZE_WORD) && (Address[1:0] != 2'b00))
                || ((Size == SIZE_HALF) && Address[0])
                || ((Address >> ADDR_BITS) != 32'd0);

    assign w_done   = (r_state == ST_WAIT) && RAMEnable && (r_cnt == '0);
    assign w_commit = w_done && !Reset && !r_rw && !r_err;

    ram_load_extend u_load_extend (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_b0       (mem[r_addr]),
        .i_b1       (mem[w_a1]),
        .i_b2       (mem[w_a2]),
        .i_b3       (mem[w_a3]),
        .o_data     (w_load)
    );

    // LATENCY=1 loads a zero count, so WAIT completes on the very next edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            MOC       <= 1'b0;
            DataOut   <= '0;
            AddrError <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (RAMEnable) begin
                        r_rw       <= RW;
                        r_size     <= Size;
                        r_unsigned <= Unsigned;
                        r_addr     <= Address[ADDR_BITS-1:0];
                        r_data     <= DataIn;
                        r_err      <= w_err;
                        r_cnt      <= 4'(LATENCY - 1);
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!RAMEnable) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_ACK;
                        MOC       <= 1'b1;
                        AddrError <= r_err;
                        DataOut   <= (r_rw && !r_err) ? w_load : '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (!RAMEnable) begin
                        MOC       <= 1'b0;
                        DataOut   <= '0;
                        AddrError <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (w_commit) begin
            case (r_size)
                SIZE_WORD: begin
                    mem[r_addr] <= r_data[31:24];
                    mem[w_a1]   <= r_data[23:16];
                    mem[w_a2]   <= r_data[15:8];
                    mem[w_a3]   <= r_data[7:0];
                end
                SIZE_HALF: begin
                    mem[r_addr] <= r_data[15:8];
                    mem[w_a1]   <= r_data[7:0];
                end
                SIZE_BYTE: mem[r_addr] <= r_data[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed handshake/error cases plus
// randomized accesses scored against a byte-array reference memory.
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    localparam int unsigned AB    = 9;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned LAT   = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RAMEnable;
    logic        RW;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        AddrError;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [0:DEPTH-1];

    always #5 Clk = ~Clk;

    data_ram_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RAMEnable (RAMEnable),
        .RW        (RW),
        .Size      (Size),
        .Unsigned  (Unsigned),
        .Address   (Address),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .MOC       (MOC),
        .AddrError (AddrError)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= DEPTH) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
        longint v = 0;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) v = v * 256 + ref_mem[a + k];
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) ref_mem[a + k] = 8'((d >> (8 * (n - 1 - k))) & 32'hFF);
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic req(input bit rw, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input string tag,
                       output logic [31:0] obs_data, output logic obs_err);
        int cyc = 0;
        bit got = 0;
        bit e = ref_err(sz, a);
        logic [31:0] exp_d = (rw && !e) ? ref_load(sz, uns, a) : 32'd0;
        @(negedge Clk);
        RAMEnable = 1'b1; RW = rw; Size = sz; Unsigned = uns; Address = a; DataIn = d;
        @(posedge Clk);
        #1;
        RW = $urandom_range(0, 1); Size = 2'($urandom); Unsigned = $urandom_range(0, 1);
        Address = $urandom; DataIn = $urandom;
        while (!got && cyc < 20) begin
            @(posedge Clk);
            cyc++;
            #1;
            if (MOC === 1'b1) got = 1;
        end
        if (!rw && !e) ref_store(sz, a, d);
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_data"}, DataOut, exp_d);
        check({tag, "_err"}, {31'd0, AddrError}, {31'd0, e});
        obs_data = DataOut;
        obs_err  = AddrError;
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk);
            #1;
            check({tag, "_hold_moc"}, {31'd0, MOC}, 32'd1);
            check({tag, "_hold_data"}, DataOut, exp_d);
        end
        RAMEnable = 1'b0;
        @(posedge Clk);
        #1;
        check({tag, "_drop_moc"}, {31'd0, MOC}, 32'd0);
        check({tag, "_drop_data"}, DataOut, 32'd0);
        check({tag, "_drop_err"}, {31'd0, AddrError}, 32'd0);
    endtask

    initial begin
        logic [31:0] od;
        logic        oe;
        Reset = 1'b1; RAMEnable = 1'b0; RW = 1'b1; Size = 2'd0; Unsigned = 1'b0;
        Address = '0; DataIn = '0;

        repeat (2) @(posedge Clk);
        #1;
        check("reset_moc", {31'd0, MOC}, 32'd0);
        check("reset_data", DataOut, 32'd0);
        check("reset_err", {31'd0, AddrError}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            check("idle_moc", {31'd0, MOC}, 32'd0);
        end

        for (int i = 0; i < DEPTH; i += 4) req(1'b0, SIZE_WORD, 1'b0, i, $urandom, 0, "fill", od, oe);
        check("fill_mem", mem_diff(), 0);

        req(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 0, "sw", od, oe);
        req(1'b1, SIZE_WORD, 1'b1, 32'h10, 32'h0, 0, "lw", od, oe);
        check("lw_const", od, 32'hDEADBEEF);
        check("m10", {24'd0, dut.mem[16]}, 32'hDE);
        check("m11", {24'd0, dut.mem[17]}, 32'hAD);
        check("m12", {24'd0, dut.mem[18]}, 32'hBE);
        check("m13", {24'd0, dut.mem[19]}, 32'hEF);

        req(1'b0, SIZE_HALF, 1'b0, 32'h20, 32'h00008001, 0, "sh_pre", od, oe);
        req(1'b1, SIZE_HALF, 1'b0, 32'h20, 32'h0, 0, "lh", od, oe);
        check("lh_const", od, 32'hFFFF8001);
        req(1'b1, SIZE_HALF, 1'b1, 32'h20, 32'h0, 0, "lhu", od, oe);
        check("lhu_const", od, 32'h00008001);
        req(1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h0, 0, "lb", od, oe);
        check("lb_const", od, 32'h00000001);
        req(1'b0, SIZE_BYTE, 1'b0, 32'h22, 32'h123456AB, 0, "sb", od, oe);
        check("sb_byte", {24'd0, dut.mem[34]}, 32'hAB);
        check("sb_mem", mem_diff(), 0);

        req(1'b1, SIZE_WORD, 1'b0, 32'h2, 32'h0, 0, "lw_misalign", od, oe);
        check("lw_misalign_const", {31'd0, oe}, 32'd1);
        req(1'b0, SIZE_WORD, 1'b0, 32'h200, 32'hCAFEF00D, 0, "sw_oob", od, oe);
        check("sw_oob_const", {31'd0, oe}, 32'd1);
        check("sw_oob_mem", mem_diff(), 0);
        req(1'b1, SIZE_ILLEGAL, 1'b0, 32'h10, 32'h0, 0, "size11", od, oe);
        check("size11_const", {31'd0, oe}, 32'd1);

        req(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 6, "hold", od, oe);

        @(negedge Clk);
        RAMEnable = 1'b1; RW = 1'b0; Size = SIZE_WORD; Address = 32'h30; DataIn = 32'h55AA55AA;
        @(posedge Clk);
        #1 RAMEnable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            check("abort_moc", {31'd0, MOC}, 32'd0);
        end
        check("abort_mem", mem_diff(), 0);

        @(negedge Clk);
        RAMEnable = 1'b1; RW = 1'b0; Size = SIZE_WORD; Address = 32'h40; DataIn = 32'h11223344;
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0; RAMEnable = 1'b0;
        check("rst_mid_moc0", {31'd0, MOC}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            check("rst_mid_moc", {31'd0, MOC}, 32'd0);
        end
        check("rst_mid_mem", mem_diff(), 0);
        req(1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h0, 0, "post_rst", od, oe);

        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 9);
            logic [1:0] sz = (r < 3) ? SIZE_WORD : (r < 6) ? SIZE_HALF : (r < 9) ? SIZE_BYTE : SIZE_ILLEGAL;
            logic [31:0] a = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 3) != 0 && sz != SIZE_ILLEGAL) a = a - (a % nbytes(sz));
            req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 2), "rand", od, oe);
        end
        check("final_mem", mem_diff(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
